// File: rtl/config_pkg.sv
// Shared configuration for the copy-engine family: pipeline depth and DMA FSM states.
package config_pkg;

   localparam int DMA_PIPELINE_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } dma_state_t;

endpackage

// File: rtl/dma_resp_fifo.sv
// In-order read-response buffer. Each entry is allocated with its write index when the
// read is issued, filled when the response returns, and popped once it has been written.
module dma_resp_fifo #(
   parameter int DEPTH  = 4,
   parameter int AW     = 30,
   parameter int DATA_W = 32,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_push,
   input  logic [AW-1:0]     i_pushAddr,
   input  logic              i_fill,
   input  logic [DATA_W-1:0] i_fillData,
   input  logic              i_pop,
   output logic              o_headFilled,
   output logic [AW-1:0]     o_headAddr,
   output logic [DATA_W-1:0] o_headData,
   output logic [CW-1:0]     o_count,
   output logic [CW-1:0]     o_outstanding
);

   logic [AW-1:0]     r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]  r_filled;
   logic [PW-1:0]     r_allocPtr;
   logic [PW-1:0]     r_fillPtr;
   logic [PW-1:0]     r_popPtr;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     r_outstanding;
   logic              w_fillOk;

   // A response with no allocated-but-unfilled entry belongs to nobody and is dropped.
   assign w_fillOk = i_fill && (r_outstanding != '0);

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_filled      <= '0;
         r_allocPtr    <= '0;
         r_fillPtr     <= '0;
         r_popPtr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
      end else begin
         if (i_push) begin
            r_filled[r_allocPtr] <= 1'b0;
            r_allocPtr           <= r_allocPtr + PW'(1);
         end
         if (w_fillOk) begin
            r_filled[r_fillPtr] <= 1'b1;
            r_fillPtr           <= r_fillPtr + PW'(1);
         end
         if (i_pop) begin
            r_popPtr <= r_popPtr + PW'(1);
         end
         r_count       <= r_count + CW'(i_push) - CW'(i_pop);
         r_outstanding <= r_outstanding + CW'(i_push) - CW'(w_fillOk);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_addr[r_allocPtr] <= i_pushAddr;
      end
      if (w_fillOk) begin
         r_data[r_fillPtr] <= i_fillData;
      end
   end

   assign o_headFilled  = (r_count != '0) && r_filled[r_popPtr];
   assign o_headAddr    = r_addr[r_popPtr];
   assign o_headData    = r_data[r_popPtr];
   assign o_count       = r_count;
   assign o_outstanding = r_outstanding;

endmodule

// File: rtl/dma_2d.sv
// Word-granular 1D memmove / strided 2D rectangle copy engine with a bounded read pipeline,
// read/write backpressure, abort with drain, and sticky error reporting.
module dma_2d import config_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16,
   parameter int DEPTH  = config_pkg::DMA_PIPELINE_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  row_len,
   input  logic [LEN_W-1:0]  rows,
   input  logic [ADDR_W-1:0] src_stride,
   input  logic [ADDR_W-1:0] dst_stride,
   input  logic              src_resident,
   input  logic              dst_resident,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              mem_read_en,
   input  logic              mem_read_ready,
   output logic [ADDR_W-3:0] mem_read_addr,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic              mem_read_valid,
   output logic              mem_write_en,
   input  logic              mem_write_ready,
   output logic [ADDR_W-3:0] mem_write_addr,
   output logic [DATA_W-1:0] mem_write_data
);

   localparam int AW = ADDR_W - 2;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = 2 * LEN_W;

   dma_state_t        r_state;
   logic              r_done;
   logic              r_error;
   logic              r_backward;
   logic [LEN_W-1:0]  r_rowLen;
   logic [LEN_W-1:0]  r_col;
   logic [AW-1:0]     r_srcBase;
   logic [AW-1:0]     r_dstBase;
   logic [AW-1:0]     r_srcStride;
   logic [AW-1:0]     r_dstStride;
   logic [AW-1:0]     r_rdAddr;
   logic [AW-1:0]     r_wrAddr;
   logic [TW-1:0]     r_issueLeft;
   logic [TW-1:0]     r_writeLeft;

   logic [AW-1:0]     w_srcIdx;
   logic [AW-1:0]     w_dstIdx;
   logic [AW-1:0]     w_lenM1;
   logic [LEN_W-1:0]  w_rowsEff;
   logic [TW-1:0]     w_total;
   logic              w_backward;
   logic              w_cmdOk;
   logic              w_readEn;
   logic              w_readHs;
   logic              w_writeEn;
   logic              w_writeHs;
   logic              w_lastCol;
   logic              w_clear;
   logic              w_headFilled;
   logic [AW-1:0]     w_headAddr;
   logic [DATA_W-1:0] w_headData;
   logic [CW-1:0]     w_fifoCount;
   logic [CW-1:0]     w_outstanding;
   logic              w_unused;

   assign w_srcIdx  = src_addr[ADDR_W-1:2];
   assign w_dstIdx  = dst_addr[ADDR_W-1:2];
   assign w_lenM1   = AW'(row_len) - AW'(1);
   assign w_rowsEff = (rows == '0) ? LEN_W'(1) : rows;
   assign w_total   = TW'(row_len) * TW'(w_rowsEff);
   assign w_cmdOk   = src_resident && dst_resident && (row_len != '0);
   assign w_unused  = ^{src_addr[1:0], dst_addr[1:0], src_stride[ADDR_W-1:AW], dst_stride[ADDR_W-1:AW]};

   // Overlapping 1D copy with the destination above the source must run top-down.
   assign w_backward = (rows <= LEN_W'(1)) && (w_dstIdx > w_srcIdx) &&
                       (({1'b0, w_srcIdx} + (AW+1)'(row_len)) > {1'b0, w_dstIdx});

   assign w_readEn  = (r_state == RUN) && (w_fifoCount < CW'(DEPTH)) && (r_issueLeft != '0);
   assign w_readHs  = w_readEn && mem_read_ready;
   assign w_writeEn = (r_state == RUN) && w_headFilled;
   assign w_writeHs = w_writeEn && mem_write_ready;
   assign w_lastCol = (r_col == r_rowLen - LEN_W'(1));
   assign w_clear   = (r_state == DRAIN) && (w_outstanding == '0);

   dma_resp_fifo #(
      .DEPTH  (DEPTH),
      .AW     (AW),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .i_clear       (w_clear),
      .i_push        (w_readHs),
      .i_pushAddr    (r_wrAddr),
      .i_fill        (mem_read_valid),
      .i_fillData    (mem_read_data),
      .i_pop         (w_writeHs),
      .o_headFilled  (w_headFilled),
      .o_headAddr    (w_headAddr),
      .o_headData    (w_headData),
      .o_count       (w_fifoCount),
      .o_outstanding (w_outstanding)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_backward  <= 1'b0;
         r_rowLen    <= '0;
         r_col       <= '0;
         r_srcBase   <= '0;
         r_dstBase   <= '0;
         r_srcStride <= '0;
         r_dstStride <= '0;
         r_rdAddr    <= '0;
         r_wrAddr    <= '0;
         r_issueLeft <= '0;
         r_writeLeft <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !w_cmdOk) begin
                  r_error <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (start) begin
                  r_error     <= 1'b0;
                  r_backward  <= w_backward;
                  r_rowLen    <= row_len;
                  r_col       <= '0;
                  r_srcBase   <= w_srcIdx;
                  r_dstBase   <= w_dstIdx;
                  r_srcStride <= src_stride[AW-1:0];
                  r_dstStride <= dst_stride[AW-1:0];
                  r_rdAddr    <= w_backward ? w_srcIdx + w_lenM1 : w_srcIdx;
                  r_wrAddr    <= w_backward ? w_dstIdx + w_lenM1 : w_dstIdx;
                  r_issueLeft <= w_total;
                  r_writeLeft <= w_total;
                  r_state     <= RUN;
               end
            end
            RUN: begin
               // Both indices advance together; the write index travels with the read in the FIFO.
               if (w_readHs) begin
                  r_issueLeft <= r_issueLeft - TW'(1);
                  if (r_backward) begin
                     r_rdAddr <= r_rdAddr - AW'(1);
                     r_wrAddr <= r_wrAddr - AW'(1);
                  end else if (w_lastCol) begin
                     r_col     <= '0;
                     r_srcBase <= r_srcBase + r_srcStride;
                     r_dstBase <= r_dstBase + r_dstStride;
                     r_rdAddr  <= r_srcBase + r_srcStride;
                     r_wrAddr  <= r_dstBase + r_dstStride;
                  end else begin
                     r_col    <= r_col + LEN_W'(1);
                     r_rdAddr <= r_rdAddr + AW'(1);
                     r_wrAddr <= r_wrAddr + AW'(1);
                  end
               end
               if (w_writeHs) begin
                  r_writeLeft <= r_writeLeft - TW'(1);
               end
               if (abort) begin
                  r_state <= DRAIN;
               end else if (w_writeHs && (r_writeLeft == TW'(1))) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DRAIN: begin
               if (w_outstanding == '0) begin
                  r_error <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy           = (r_state != IDLE);
   assign done           = r_done;
   assign error          = r_error;
   assign mem_read_en    = w_readEn;
   assign mem_read_addr  = w_readEn ? r_rdAddr : '0;
   assign mem_write_en   = w_writeEn;
   assign mem_write_addr = w_writeEn ? w_headAddr : '0;
   assign mem_write_data = w_writeEn ? w_headData : '0;

endmodule

// File: tb/tb_dma_2d.sv
// Scoreboard bench for dma_2d: directed commands push expected writes, a monitor with a
// behavioural memory model pops and compares every accepted write.
module tb_dma_2d;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] row_len;
   logic [15:0] rows;
   logic [31:0] src_stride;
   logic [31:0] dst_stride;
   logic        src_resident;
   logic        dst_resident;
   logic        abort;
   logic        busy;
   logic        done;
   logic        error;
   logic        mem_read_en;
   logic        mem_read_ready;
   logic [29:0] mem_read_addr;
   logic [31:0] mem_read_data;
   logic        mem_read_valid;
   logic        mem_write_en;
   logic        mem_write_ready;
   logic [29:0] mem_write_addr;
   logic [31:0] mem_write_data;

   int nVec = 0;
   int nFail = 0;
   int rdAcc = 0;
   int wrAcc = 0;
   int respCnt = 0;
   int cycleCnt = 0;
   int rdLat = 1;
   int maxInflight = 0;
   logic trackInflight = 1'b0;
   logic noWrites = 1'b0;

   logic [31:0] mem [1024];
   logic [29:0] expAddr [$];
   logic [31:0] expData [$];
   logic [31:0] pendData [$];
   int          pendDue [$];

   dma_2d #(
      .DATA_W (32),
      .ADDR_W (32),
      .LEN_W  (16),
      .DEPTH  (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .src_addr        (src_addr),
      .dst_addr        (dst_addr),
      .row_len         (row_len),
      .rows            (rows),
      .src_stride      (src_stride),
      .dst_stride      (dst_stride),
      .src_resident    (src_resident),
      .dst_resident    (dst_resident),
      .abort           (abort),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .mem_read_en     (mem_read_en),
      .mem_read_ready  (mem_read_ready),
      .mem_read_addr   (mem_read_addr),
      .mem_read_data   (mem_read_data),
      .mem_read_valid  (mem_read_valid),
      .mem_write_en    (mem_write_en),
      .mem_write_ready (mem_write_ready),
      .mem_write_addr  (mem_write_addr),
      .mem_write_data  (mem_write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pushExp(input logic [29:0] a, input logic [31:0] d);
      expAddr.push_back(a);
      expData.push_back(d);
   endtask

   task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] rl,
                                input logic [15:0] rw, input logic [31:0] ss, input logic [31:0] ds,
                                input logic sres, input logic dres);
      @(posedge clk); #1;
      src_addr     = s;
      dst_addr     = d;
      row_len      = rl;
      rows         = rw;
      src_stride   = ss;
      dst_stride   = ds;
      src_resident = sres;
      dst_resident = dres;
      start        = 1'b1;
      @(posedge clk); #1;
      start        = 1'b0;
      src_resident = 1'b1;
      dst_resident = 1'b1;
   endtask

   // Counts negedges after the start edge until done; also checks the pulse is one cycle wide.
   task automatic waitDone(input int bound, output int cyc, output logic errAtDone);
      logic seen;
      seen      = 1'b0;
      cyc       = 0;
      errAtDone = 1'b0;
      while (!seen && cyc < bound) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            seen      = 1'b1;
            errAtDone = error;
         end
      end
      if (!seen) begin
         nVec++;
         nFail++;
         $display("[TB] FAIL done timeout: no done within %0d cycles", bound);
      end else begin
         @(negedge clk);
         checkOutput("done one-cycle", done, 0);
         checkOutput("busy after done", busy, 0);
      end
   endtask

   // Monitor and memory model: reads return rdLat cycles after the handshake, in order.
   initial begin
      mem_read_valid = 1'b0;
      mem_read_data  = '0;
      forever begin
         @(negedge clk);
         if (mem_read_en && mem_read_ready) begin
            pendData.push_back(mem[mem_read_addr[9:0]]);
            pendDue.push_back(cycleCnt + rdLat);
            rdAcc++;
         end
         if (mem_write_en && mem_write_ready) begin
            if (noWrites || expAddr.size() == 0) begin
               nVec++;
               nFail++;
               $display("[TB] FAIL unexpected write: got addr 0x%0h, required no write", mem_write_addr);
            end else begin
               checkOutput("write addr", mem_write_addr, expAddr.pop_front());
               checkOutput("write data", mem_write_data, expData.pop_front());
            end
            mem[mem_write_addr[9:0]] = mem_write_data;
            wrAcc++;
         end
         if (trackInflight && (rdAcc - wrAcc) > maxInflight) maxInflight = rdAcc - wrAcc;
         @(posedge clk);
         cycleCnt++;
         #1;
         if (pendDue.size() > 0 && pendDue[0] <= cycleCnt) begin
            mem_read_valid = 1'b1;
            mem_read_data  = pendData.pop_front();
            void'(pendDue.pop_front());
            respCnt++;
         end else begin
            mem_read_valid = 1'b0;
            mem_read_data  = '0;
         end
      end
   end

   // Write address/data must not move while the memory stalls the write.
   initial begin
      logic        prevStall;
      logic [29:0] prevAddr;
      logic [31:0] prevData;
      prevStall = 1'b0;
      prevAddr  = '0;
      prevData  = '0;
      forever begin
         @(negedge clk);
         if (prevStall && mem_write_en) begin
            checkOutput("stall addr stable", mem_write_addr, prevAddr);
            checkOutput("stall data stable", mem_write_data, prevData);
         end
         prevStall = mem_write_en && !mem_write_ready;
         prevAddr  = mem_write_addr;
         prevData  = mem_write_data;
      end
   end

   initial begin
      int          cyc;
      int          base;
      int          rdBase;
      logic        err;
      logic [31:0] shifted [5];
      logic [29:0] t3Addr [6];
      logic [31:0] t3Data [6];

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; row_len = '0; rows = '0;
      src_stride = '0; dst_stride = '0; src_resident = 1'b1; dst_resident = 1'b1;
      mem_read_ready = 1'b1; mem_write_ready = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hD000_0000 | i;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset error", error, 0);
      checkOutput("reset read_en", mem_read_en, 0);
      checkOutput("reset write_en", mem_write_en, 0);

      $display("[TB] case 1: forward 1D copy of 4 words");
      for (int k = 0; k < 4; k++) pushExp(30'd128 + 30'(k), 32'hD000_0040 + 32'(k));
      applyStimulus(32'h100, 32'h200, 16'd4, 16'd1, 0, 0, 1'b1, 1'b1);
      waitDone(100, cyc, err);
      checkOutput("c1 error", err, 0);
      checkOutput("c1 scoreboard empty", expAddr.size(), 0);

      $display("[TB] case 2: overlapping copy runs backward");
      for (int k = 3; k >= 0; k--) pushExp(30'd65 + 30'(k), 32'hD000_0040 + 32'(k));
      applyStimulus(32'h100, 32'h104, 16'd4, 16'd1, 0, 0, 1'b1, 1'b1);
      waitDone(100, cyc, err);
      checkOutput("c2 error", err, 0);
      checkOutput("c2 scoreboard empty", expAddr.size(), 0);
      shifted = '{32'hD000_0040, 32'hD000_0040, 32'hD000_0041, 32'hD000_0042, 32'hD000_0043};
      for (int k = 0; k < 5; k++) checkOutput("c2 memory", mem[64 + k], shifted[k]);

      $display("[TB] case 3: 2D strided copy");
      t3Addr = '{30'd256, 30'd257, 30'd260, 30'd261, 30'd264, 30'd265};
      t3Data = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0008, 32'hD000_0009, 32'hD000_0010, 32'hD000_0011};
      for (int k = 0; k < 6; k++) pushExp(t3Addr[k], t3Data[k]);
      applyStimulus(32'h0, 32'h400, 16'd2, 16'd3, 32'd8, 32'd4, 1'b1, 1'b1);
      waitDone(100, cyc, err);
      checkOutput("c3 error", err, 0);
      checkOutput("c3 scoreboard empty", expAddr.size(), 0);

      $display("[TB] case 4: write backpressure mid-transfer");
      for (int k = 0; k < 8; k++) pushExp(30'd384 + 30'(k), 32'hD000_00C0 + 32'(k));
      maxInflight = 0;
      trackInflight = 1'b1;
      base = wrAcc;
      applyStimulus(32'h300, 32'h600, 16'd8, 16'd1, 0, 0, 1'b1, 1'b1);
      cyc = 0;
      while (wrAcc < base + 1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("c4 first write seen", (wrAcc >= base + 1), 1);
      mem_write_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 mem_write_ready = 1'b1;
      waitDone(200, cyc, err);
      trackInflight = 1'b0;
      checkOutput("c4 error", err, 0);
      checkOutput("c4 max outstanding", maxInflight, DEPTH);
      checkOutput("c4 scoreboard empty", expAddr.size(), 0);

      $display("[TB] case 5: abort after 3 writes with slow reads");
      rdLat = 3;
      for (int k = 0; k < 3; k++) pushExp(30'd768 + 30'(k), 32'hD000_0200 + 32'(k));
      base = wrAcc;
      applyStimulus(32'h800, 32'hC00, 16'd16, 16'd1, 0, 0, 1'b1, 1'b1);
      cyc = 0;
      while (wrAcc < base + 3 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      abort = 1'b1;
      mem_write_ready = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0;
      mem_write_ready = 1'b1;
      noWrites = 1'b1;
      waitDone(200, cyc, err);
      checkOutput("c5 error", err, 1);
      checkOutput("c5 reads returned before done", pendDue.size(), 0);
      checkOutput("c5 responses equal requests", respCnt, rdAcc);
      checkOutput("c5 write count", wrAcc - base, 3);
      rdLat = 1;

      $display("[TB] case 6: rejected starts and mid-transfer reset");
      rdBase = rdAcc;
      applyStimulus(32'h100, 32'h200, 16'd4, 16'd1, 0, 0, 1'b0, 1'b1);
      waitDone(20, cyc, err);
      checkOutput("c6 nonresident latency", cyc, 1);
      checkOutput("c6 nonresident error", err, 1);
      applyStimulus(32'h100, 32'h200, 16'd0, 16'd1, 0, 0, 1'b1, 1'b1);
      waitDone(20, cyc, err);
      checkOutput("c6 zero-length latency", cyc, 1);
      checkOutput("c6 zero-length error", err, 1);
      checkOutput("c6 no read traffic", rdAcc - rdBase, 0);

      mem_write_ready = 1'b0;
      applyStimulus(32'h300, 32'h700, 16'd8, 16'd1, 0, 0, 1'b1, 1'b1);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("c6 reset busy", busy, 0);
      checkOutput("c6 reset done", done, 0);
      checkOutput("c6 reset error", error, 0);
      checkOutput("c6 reset read_en", mem_read_en, 0);
      checkOutput("c6 reset read_addr", mem_read_addr, 0);
      checkOutput("c6 reset write_en", mem_write_en, 0);
      checkOutput("c6 reset write_addr", mem_write_addr, 0);
      checkOutput("c6 reset write_data", mem_write_data, 0);
      #1 mem_write_ready = 1'b1;
      repeat (8) @(negedge clk);
      noWrites = 1'b0;

      $display("[TB] single-word latency and error clear");
      pushExp(30'd32, 32'hD000_0010);
      applyStimulus(32'h40, 32'h80, 16'd1, 16'd0, 0, 0, 1'b1, 1'b1);
      waitDone(50, cyc, err);
      checkOutput("single-word latency", cyc, 4);
      checkOutput("error cleared by start", err, 0);
      checkOutput("final scoreboard empty", expAddr.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
